// File: rtl/tdma_recv_ctrl.sv
// TDMA receive controller: buffers received words in a small FIFO and exposes
// it through a 4-register Avalon-MM slave with overflow/drop tracking and a level irq.
module tdma_recv_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] recv_data,
  input  logic        recv_valid,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_en_q, irq_en_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          irq_q, irq_d;

  logic        pop, push, drop_evt, flush, ctrl_wr, drop_wr;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:3];

  always_comb begin
    pop      = read && (address == 2'd0) && (count_q != '0);
    ctrl_wr  = write && (address == 2'd2);
    drop_wr  = write && (address == 2'd3);
    flush    = ctrl_wr && writedata[1];
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    push     = recv_valid && !flush && ((count_q != FULL_CNT) || pop);
    drop_evt = recv_valid && !flush && (count_q == FULL_CNT) && !pop;

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    drop_cnt_d = drop_cnt_q;
    readdata_d = readdata_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW + 1)'(1);
      else if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end

    if (ctrl_wr) begin
      irq_en_d = writedata[0];
      if (writedata[2]) overflow_d = 1'b0;
    end
    if (drop_evt) overflow_d = 1'b1;

    if (drop_wr)
      drop_cnt_d = drop_evt ? 16'd1 : 16'd0;
    else if (drop_evt && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;

    status         = '0;
    status[AW:0]   = count_q;
    status[8]      = (count_q == '0);
    status[9]      = (count_q == FULL_CNT);
    status[10]     = overflow_q;
    status[11]     = irq_en_q;

    if (read) begin
      case (address)
        2'd0:    readdata_d = pop ? mem_q[rd_ptr_q] : 32'd0;
        2'd1:    readdata_d = status;
        2'd2:    readdata_d = {31'd0, irq_en_q};
        default: readdata_d = {16'd0, drop_cnt_q};
      endcase
    end

    // Built from registered state, so irq trails the causing change by one edge.
    irq_d = irq_en_q && ((count_q != '0) || overflow_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= recv_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      drop_cnt_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      drop_cnt_q <= drop_cnt_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
